// File: rtl/vga_timing_gen_if.sv
// Video output bundle of the raster timing generator.
//   hs, vs, de               : sync and display enable (delay-line aligned)
//   hc_visible, vc_visible   : visible pixel coordinates, 0 outside active video
//   line_start, frame_start  : one-pixel-period strobes (delay-line aligned)
//   frame_cnt                : completed-frame counter
// master drives the bundle (the generator); slave consumes it.
interface vga_timing_gen_if #(
  parameter int unsigned CW  = 11,
  parameter int unsigned FCW = 16
);
  logic           hs;
  logic           vs;
  logic           de;
  logic [CW-1:0]  hc_visible;
  logic [CW-1:0]  vc_visible;
  logic           line_start;
  logic           frame_start;
  logic [FCW-1:0] frame_cnt;

  modport master (
    output hs, vs, de, hc_visible, vc_visible, line_start, frame_start, frame_cnt
  );

  modport slave (
    input hs, vs, de, hc_visible, vc_visible, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator (VGA/SVGA/XGA class modes).
//   clk_vga : pixel-domain clock
//   rst     : synchronous active-high reset, overrides pix_en
//   pix_en  : pixel clock enable; all state advances only when high
//   vid     : video output bundle (vga_timing_gen_if.master)
// Line/frame order is active, front porch, sync, back porch. Coordinates
// are one pix_en step behind the counters; sync/de/strobes are a further
// SYNC_DLY pix_en steps behind to match the downstream pixel pipeline.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11,
  parameter int unsigned FCW      = 16,
  parameter int unsigned SYNC_DLY = 0
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic              pix_en,
  vga_timing_gen_if.master  vid
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Bit positions of the delayed sync bundle
  localparam int unsigned SB_W  = 5;
  localparam int unsigned SB_HS = 4;
  localparam int unsigned SB_VS = 3;
  localparam int unsigned SB_DE = 2;
  localparam int unsigned SB_LS = 1;
  localparam int unsigned SB_FS = 0;

  localparam logic [SB_W-1:0] SB_IDLE = {~HS_POL, ~VS_POL, 1'b0, 1'b0, 1'b0};

  // Stage 0: raster counters
  logic [CW-1:0]  hc_q, hc_d;
  logic [CW-1:0]  vc_q, vc_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           hc_wrap_c;
  logic           vc_wrap_c;

  // Stage 1 coordinates and the sync delay line (index 0 is stage 1)
  logic [CW-1:0]   hcv_q, hcv_d;
  logic [CW-1:0]   vcv_q, vcv_d;
  logic [SB_W-1:0] dly_q [SYNC_DLY+1];
  logic [SB_W-1:0] dly_d [SYNC_DLY+1];

  logic            de_c;
  logic            hs_act_c;
  logic            vs_act_c;
  logic [SB_W-1:0] sync_c;

  // Counter next state
  always_comb begin
    hc_wrap_c = (hc_q == CW'(H_TOTAL - 1));
    vc_wrap_c = (vc_q == CW'(V_TOTAL - 1));
    hc_d      = hc_wrap_c ? '0 : hc_q + CW'(1);
    vc_d      = vc_q;
    fcnt_d    = fcnt_q;
    if (hc_wrap_c) begin
      vc_d = vc_wrap_c ? '0 : vc_q + CW'(1);
      if (vc_wrap_c) begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  // Stage 1 decode of the current counter state
  always_comb begin
    de_c     = (hc_q < CW'(H_ACTIVE)) && (vc_q < CW'(V_ACTIVE));
    hs_act_c = (hc_q >= CW'(HS_START)) && (hc_q < CW'(HS_END));
    vs_act_c = (vc_q >= CW'(VS_START)) && (vc_q < CW'(VS_END));
    hcv_d    = de_c ? hc_q : '0;
    vcv_d    = de_c ? vc_q : '0;
    sync_c          = SB_IDLE;
    sync_c[SB_HS]   = hs_act_c ? HS_POL : ~HS_POL;
    sync_c[SB_VS]   = vs_act_c ? VS_POL : ~VS_POL;
    sync_c[SB_DE]   = de_c;
    sync_c[SB_LS]   = (hc_q == '0);
    sync_c[SB_FS]   = (hc_q == '0) && (vc_q == '0);
  end

  // Delay line shift
  always_comb begin
    for (int unsigned i = 0; i <= SYNC_DLY; i++) begin
      dly_d[i] = SB_IDLE;
    end
    dly_d[0] = sync_c;
    for (int unsigned i = 1; i <= SYNC_DLY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // All state registers; reset wins over pix_en
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hc_q   <= '0;
      vc_q   <= '0;
      fcnt_q <= '0;
      hcv_q  <= '0;
      vcv_q  <= '0;
      for (int unsigned i = 0; i <= SYNC_DLY; i++) begin
        dly_q[i] <= SB_IDLE;
      end
    end else if (pix_en) begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      fcnt_q <= fcnt_d;
      hcv_q  <= hcv_d;
      vcv_q  <= vcv_d;
      for (int unsigned i = 0; i <= SYNC_DLY; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  assign vid.hs          = dly_q[SYNC_DLY][SB_HS];
  assign vid.vs          = dly_q[SYNC_DLY][SB_VS];
  assign vid.de          = dly_q[SYNC_DLY][SB_DE];
  assign vid.line_start  = dly_q[SYNC_DLY][SB_LS];
  assign vid.frame_start = dly_q[SYNC_DLY][SB_FS];
  assign vid.hc_visible  = hcv_q;
  assign vid.vc_visible  = vcv_q;
  assign vid.frame_cnt   = fcnt_q;

endmodule
